// File: rtl/seq_mult_booth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_booth_pkg
// Brief    : Shared types and width helpers for the Booth sequential multiplier
// Revision : 1.0 - initial release
// ============================================================================
package seq_mult_booth_pkg;

    localparam int ST_WIDTH = 1;

    typedef enum logic [ST_WIDTH-1:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Operands carry one guard bit so unsigned values survive sign extension.
    function automatic int ext_w(input int dp_width);
        return dp_width + 1;
    endfunction

    function automatic int cntr_w(input int dp_width);
        return $clog2(dp_width + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_booth_arith_shift.sv
`default_nettype none
// ============================================================================
// Module   : booth_arith_shift
// Brief    : Combinational arithmetic right shift, truncated to the output width
// Revision : 1.0 - initial release
// ============================================================================
module booth_arith_shift #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16,
    parameter int SH_W  = 4
) (
    input  logic [IN_W-1:0]  i_data,
    input  logic [SH_W-1:0]  i_shamt,
    output logic [OUT_W-1:0] o_data
);

    always_comb begin
        o_data = OUT_W'($signed(i_data) >>> i_shamt);
    end

endmodule
`default_nettype wire

// File: rtl/seq_mult_booth.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_booth
// Brief    : Radix-2 Booth sequential multiplier with early termination
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_booth
    import seq_mult_booth_pkg::*;
#(
    parameter int DP_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        start,
    input  logic                        signed_mode,
    input  logic [DP_WIDTH-1:0]         multiplicand,
    input  logic [DP_WIDTH-1:0]         multiplier,
    output logic                        rdy,
    output logic                        done,
    output logic [2*DP_WIDTH-1:0]       product,
    output logic [cntr_w(DP_WIDTH)-1:0] steps
);

    localparam int c_EXT_W  = ext_w(DP_WIDTH);
    localparam int c_CNTR_W = cntr_w(DP_WIDTH);
    localparam logic [c_EXT_W-1:0] c_ONES = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_EXT_W-1:0]    r_m;
    logic [c_EXT_W-1:0]    r_a;
    logic [c_EXT_W-1:0]    r_q;
    logic                  r_qm1;
    logic [c_CNTR_W-1:0]   r_cntr;
    logic [c_CNTR_W-1:0]   r_nsteps;
    logic                  r_done;
    logic [2*DP_WIDTH-1:0] r_product;
    logic [c_CNTR_W-1:0]   r_steps;

    logic                  w_accept;
    logic [c_EXT_W-1:0]    w_mcand_ext;
    logic [c_EXT_W-1:0]    w_mplier_ext;
    logic [c_EXT_W-1:0]    w_mask;
    logic [c_EXT_W-1:0]    w_low;
    logic                  w_skip;
    logic [c_EXT_W-1:0]    w_a_sum;
    logic [2*DP_WIDTH-1:0] w_shifted;

    assign w_accept     = start && (r_state == ST_IDLE);
    assign w_mcand_ext  = {signed_mode & multiplicand[DP_WIDTH-1], multiplicand};
    assign w_mplier_ext = {signed_mode & multiplier[DP_WIDTH-1], multiplier};

    // Remaining Booth digits are all zero when the unconsumed multiplier bits
    // and the look-behind bit are uniformly 0 or uniformly 1.
    assign w_mask = ~(c_ONES << r_cntr);
    assign w_low  = r_q & w_mask;
    assign w_skip = (r_cntr == '0)
                 || ((w_low == '0) && !r_qm1)
                 || ((w_low == w_mask) && r_qm1);

    always_comb begin
        w_a_sum = r_a;
        case ({r_q[0], r_qm1})
            2'b10:   w_a_sum = r_a - r_m;
            2'b01:   w_a_sum = r_a + r_m;
            default: w_a_sum = r_a;
        endcase
    end

    booth_arith_shift #(
        .IN_W  (2 * c_EXT_W),
        .OUT_W (2 * DP_WIDTH),
        .SH_W  (c_CNTR_W)
    ) u_shift (
        .i_data  ({r_a, r_q}),
        .i_shamt (r_cntr),
        .o_data  (w_shifted)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_skip) w_state_nxt = ST_IDLE;
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_cntr    <= '0;
            r_nsteps  <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
            r_steps   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_m      <= w_mcand_ext;
                r_a      <= '0;
                r_q      <= w_mplier_ext;
                r_qm1    <= 1'b0;
                r_cntr   <= c_CNTR_W'(c_EXT_W);
                r_nsteps <= '0;
            end else if (r_state == ST_RUN) begin
                if (w_skip) begin
                    r_product <= w_shifted;
                    r_steps   <= r_nsteps;
                    r_done    <= 1'b1;
                end else begin
                    r_a      <= {w_a_sum[c_EXT_W-1], w_a_sum[c_EXT_W-1:1]};
                    r_q      <= {w_a_sum[0], r_q[c_EXT_W-1:1]};
                    r_qm1    <= r_q[0];
                    r_cntr   <= r_cntr - 1'b1;
                    r_nsteps <= r_nsteps + 1'b1;
                end
            end
        end
    end

    assign rdy     = (r_state == ST_IDLE);
    assign done    = r_done;
    assign product = r_product;
    assign steps   = r_steps;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_booth.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_booth
// Brief    : Directed and sweep bench for the Booth sequential multiplier
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_booth;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  multiplicand = '0;
    logic [7:0]  multiplier = '0;
    logic        rdy;
    logic        done;
    logic [15:0] product;
    logic [3:0]  steps;

    int checks = 0;
    int failures = 0;

    seq_mult_booth #(.DP_WIDTH(8)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .rdy          (rdy),
        .done         (done),
        .product      (product),
        .steps        (steps)
    );

    always #5 clk = ~clk;

    // lat counts edges from the accepting edge through the edge that sees done.
    task automatic run_op(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] p, output logic [3:0] st,
                          output int lat, output logic to);
        int guard;
        guard = 0;
        to    = 1'b0;
        @(negedge clk);
        while (!rdy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        signed_mode  = sm;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) to = 1'b1;
        lat = lat;
        p   = product;
        st  = steps;
    endtask

    task automatic test_reset();
        #2 rst_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (product !== 16'h0000) begin failures++; $display("FAIL reset_product: got %h expected 0000", product); end
        checks++; if (steps !== 4'd0) begin failures++; $display("FAIL reset_steps: got %0d expected 0", steps); end
        rst_b = 1'b1;
    endtask

    task automatic test_zero_skip();
        logic [15:0] p; logic [3:0] st; int lat; logic to;
        run_op(1'b0, 8'hAB, 8'h00, p, st, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL zero_timeout: got %b expected 0", to); end
        checks++; if (p !== 16'h0000) begin failures++; $display("FAIL zero_product: got %h expected 0000", p); end
        checks++; if (st !== 4'd0) begin failures++; $display("FAIL zero_steps: got %0d expected 0", st); end
        checks++; if (lat != 2) begin failures++; $display("FAIL zero_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_booth_count();
        logic [15:0] p; logic [3:0] st; int lat; logic to;
        run_op(1'b0, 8'h07, 8'h01, p, st, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL cnt_u_timeout: got %b expected 0", to); end
        checks++; if (p !== 16'h0007) begin failures++; $display("FAIL cnt_u_product: got %h expected 0007", p); end
        checks++; if (st !== 4'd2) begin failures++; $display("FAIL cnt_u_steps: got %0d expected 2", st); end
        checks++; if (lat != 4) begin failures++; $display("FAIL cnt_u_latency: got %0d expected 4", lat); end
        run_op(1'b1, 8'h05, 8'hFF, p, st, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL cnt_s_timeout: got %b expected 0", to); end
        checks++; if (p !== 16'hFFFB) begin failures++; $display("FAIL cnt_s_product: got %h expected fffb", p); end
        checks++; if (st !== 4'd1) begin failures++; $display("FAIL cnt_s_steps: got %0d expected 1", st); end
        checks++; if (lat != 3) begin failures++; $display("FAIL cnt_s_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] p; logic [3:0] st; int lat; logic to;
        @(negedge clk);
        signed_mode  = 1'b0;
        multiplicand = 8'hFF;
        multiplier   = 8'hFF;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL midrst_running: got rdy=%b expected 0", rdy); end
        rst_b = 1'b0;
        #1;
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL midrst_rdy: got %b expected 1", rdy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", done); end
        checks++; if (product !== 16'h0000) begin failures++; $display("FAIL midrst_product: got %h expected 0000", product); end
        checks++; if (steps !== 4'd0) begin failures++; $display("FAIL midrst_steps: got %0d expected 0", steps); end
        @(negedge clk);
        rst_b = 1'b1;
        run_op(1'b0, 8'h03, 8'h04, p, st, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL midrst_next_timeout: got %b expected 0", to); end
        checks++; if (p !== 16'h000C) begin failures++; $display("FAIL midrst_next_product: got %h expected 000c", p); end
    endtask

    task automatic test_extremes();
        logic        sm_t [7];
        logic [7:0]  a_t  [7];
        logic [7:0]  b_t  [7];
        logic [15:0] e_t  [7];
        logic [15:0] p; logic [3:0] st; int lat; logic to;
        sm_t = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
        a_t  = '{8'h80, 8'h80, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h03};
        b_t  = '{8'h80, 8'h7F, 8'hFF, 8'hFF, 8'h02, 8'h7F, 8'hFD};
        e_t  = '{16'h4000, 16'hC080, 16'hFE01, 16'h0001, 16'h0100, 16'h3F01, 16'hFFF7};
        for (int i = 0; i < 7; i++) begin
            run_op(sm_t[i], a_t[i], b_t[i], p, st, lat, to);
            checks++;
            if (to !== 1'b0 || p !== e_t[i]) begin
                failures++;
                $display("FAIL extreme_%0d: %h x %h got %h expected %h (timeout=%b)", i, a_t[i], b_t[i], p, e_t[i], to);
            end
            if (i == 2) begin
                checks++; if (st > 4'd9) begin failures++; $display("FAIL extreme_ff_steps: got %0d expected <=9", st); end
                checks++; if (lat > 11) begin failures++; $display("FAIL extreme_ff_latency: got %0d expected <=11", lat); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        sm_t [3];
        logic [7:0]  a_t  [3];
        logic [7:0]  b_t  [3];
        logic [15:0] e_t  [3];
        int          guard;
        int          dones;
        sm_t = '{1'b0, 1'b1, 1'b0};
        a_t  = '{8'h12, 8'hF0, 8'h0F};
        b_t  = '{8'h34, 8'h10, 8'h0F};
        e_t  = '{16'h03A8, 16'hFF00, 16'h00E1};
        guard = 0;
        @(negedge clk);
        while (!rdy && guard < 40) begin @(negedge clk); guard++; end
        start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            signed_mode  = sm_t[op];
            multiplicand = a_t[op];
            multiplier   = b_t[op];
            @(negedge clk);
            checks++; if (rdy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept_%0d: got rdy=%b done=%b expected 0 0", op, rdy, done); end
            signed_mode  = ~sm_t[op];
            multiplicand = 8'hFF;
            multiplier   = 8'hFE;
            dones = 0;
            guard = 0;
            while (dones == 0 && guard < 20) begin
                @(negedge clk);
                guard++;
                if (done === 1'b1) dones++;
                else if (rdy !== 1'b0) begin
                    checks++; failures++;
                    $display("FAIL b2b_rdy_in_run_%0d: got rdy=%b expected 0", op, rdy);
                end
            end
            checks++; if (dones != 1) begin failures++; $display("FAIL b2b_done_%0d: got %0d pulses expected 1", op, dones); end
            checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy_with_done_%0d: got %b expected 1", op, rdy); end
            checks++; if (product !== e_t[op]) begin failures++; $display("FAIL b2b_product_%0d: got %h expected %h", op, product, e_t[op]); end
        end
        start = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_width: got %b expected 0", done); end
    endtask

    task automatic test_sweep();
        logic [15:0] p; logic [3:0] st; int lat; logic to;
        logic [7:0]  a;
        logic [7:0]  b;
        int          x;
        int          y;
        logic [15:0] exp_p;
        int          bad;
        bad = 0;
        for (int mode = 0; mode < 2; mode++) begin
            for (int i = 0; i < 1200; i++) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                run_op(mode[0], a, b, p, st, lat, to);
                x = (mode == 1) ? int'($signed(a)) : int'(a);
                y = (mode == 1) ? int'($signed(b)) : int'(b);
                exp_p = 16'(x * y);
                checks++;
                if (to !== 1'b0 || p !== exp_p || st > 4'd9 || lat != int'(st) + 2) begin
                    failures++;
                    if (bad < 10)
                        $display("FAIL sweep m=%0d %h x %h: got %h steps=%0d lat=%0d expected %h lat=steps+2", mode, a, b, p, st, lat, exp_p);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_skip();
        test_booth_count();
        test_reset_mid_run();
        test_extremes();
        test_back_to_back();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
